// File: rtl/weight_fetch_ctrl_pkg.sv
// Shared CNN weight-fetch definitions: FSM encoding, default kernel geometry, ROM base.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package weight_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } wfc_state_e;

    localparam int WFC_KERNEL_TAPS = 9;   // 3x3 kernel
    localparam int WFC_NUM_KERNELS = 7;
    localparam int WFC_BASE_ADDR   = 0;   // must agree with the ROM init range

    // Width of a tap counter; never zero so a 1-tap kernel still elaborates.
    function automatic int wfc_tap_bits(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/weight_fetch_ctrl_if.sv
// Bus bundle between the weight fetch controller and its parent (layer FSM, ROM, conv engine).
// Latency: n/a (wires only). master = weight_fetch_ctrl, slave = parent side.
// Backpressure: kernel_valid/kernel_ready handshake on the packed kernel stream.
interface weight_fetch_ctrl_if #(
    parameter int RAM_WIDTH   = 4,
    parameter int ADDR_BITS   = 6,
    parameter int KERNEL_TAPS = 9,
    parameter int KSEL_BITS   = 3
);
    logic                             start;
    logic                             start_all;
    logic [KSEL_BITS-1:0]             kernel_sel;
    logic [ADDR_BITS-1:0]             rom_addr;
    logic [RAM_WIDTH-1:0]             rom_data;
    logic [KERNEL_TAPS*RAM_WIDTH-1:0] kernel_data;
    logic [KSEL_BITS-1:0]             kernel_idx;
    logic                             kernel_valid;
    logic                             kernel_ready;
    logic                             busy;
    logic                             done;
    logic                             sel_err;

    modport master (
        input  start, start_all, kernel_sel, rom_data, kernel_ready,
        output rom_addr, kernel_data, kernel_idx, kernel_valid, busy, done, sel_err
    );

    modport slave (
        output start, start_all, kernel_sel, rom_data, kernel_ready,
        input  rom_addr, kernel_data, kernel_idx, kernel_valid, busy, done, sel_err
    );
endinterface

// File: rtl/weight_fetch_ctrl_kernel_pack_reg.sv
// KERNEL_TAPS x RAM_WIDTH pack register with tap-indexed write; tap 0 in the low bits.
// Latency: write visible on data_o the cycle after wr_en_i.
// Backpressure: none; holds contents until a slot is rewritten.
// Ports: clk, rst_n, wr_en_i, wr_tap_i, wr_dat_i in; data_o (packed kernel) out.
module weight_fetch_ctrl_kernel_pack_reg #(
    parameter int TAPS     = 9,
    parameter int WIDTH    = 4,
    parameter int TAP_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [TAP_BITS-1:0]      wr_tap_i,
    input  logic [WIDTH-1:0]         wr_dat_i,
    output logic [TAPS*WIDTH-1:0]    data_o
);
    logic [TAPS-1:0][WIDTH-1:0] pack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
        end else begin
            for (int i = 0; i < TAPS; i++) begin
                if (wr_en_i && (wr_tap_i == TAP_BITS'(i))) begin
                    pack_q[i] <= wr_dat_i;
                end
            end
        end
    end

    assign data_o = pack_q;
endmodule

// File: rtl/weight_fetch_ctrl.sv
// Fetches one kernel (or sweeps all) tap by tap from the weight ROM and presents it packed.
// Latency: start -> KERNEL_TAPS fetch cycles -> kernel_valid on cycle KERNEL_TAPS+1.
// Backpressure: kernel_valid and kernel_data hold until kernel_ready; start ignored while busy.
// Ports: clk, rst_n plain; bus (master) carries start/start_all/kernel_sel requests,
//        rom_addr/rom_data ROM port, kernel_* stream, busy/done/sel_err status.
module weight_fetch_ctrl
    import weight_fetch_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH   = 4,
    parameter int ADDR_BITS   = 6,
    parameter int KERNEL_TAPS = WFC_KERNEL_TAPS,
    parameter int NUM_KERNELS = WFC_NUM_KERNELS,
    parameter int BASE_ADDR   = WFC_BASE_ADDR,
    parameter int KSEL_BITS   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    weight_fetch_ctrl_if.master bus
);
    localparam int TAP_BITS = wfc_tap_bits(KERNEL_TAPS);
    localparam int AW       = ADDR_BITS + KSEL_BITS;
    localparam logic [TAP_BITS-1:0]  LAST_TAP = TAP_BITS'(KERNEL_TAPS - 1);
    localparam logic [KSEL_BITS-1:0] LAST_K   = KSEL_BITS'(NUM_KERNELS - 1);

    wfc_state_e             state_q;
    logic [TAP_BITS-1:0]    tap_q;
    logic [KSEL_BITS-1:0]   cur_k_q;
    logic                   sweep_q;
    logic                   done_q;
    logic                   sel_err_q;

    logic                   fetching;
    logic                   sel_ok;

    assign fetching = (state_q == ST_FETCH);
    assign sel_ok   = 32'(bus.kernel_sel) < 32'(NUM_KERNELS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            cur_k_q   <= '0;
            sweep_q   <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // start_all wins over a simultaneous start
                    if (bus.start_all) begin
                        cur_k_q <= '0;
                        tap_q   <= '0;
                        sweep_q <= 1'b1;
                        state_q <= ST_FETCH;
                    end else if (bus.start) begin
                        if (sel_ok) begin
                            cur_k_q <= bus.kernel_sel;
                            tap_q   <= '0;
                            sweep_q <= 1'b0;
                            state_q <= ST_FETCH;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (tap_q == LAST_TAP) begin
                        tap_q   <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        tap_q <= tap_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.kernel_ready) begin
                        if (sweep_q && (cur_k_q < LAST_K)) begin
                            cur_k_q <= cur_k_q + 1'b1;
                            state_q <= ST_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Address math at AW bits, then truncated; parameter bounds keep it from wrapping.
    assign bus.rom_addr = fetching
        ? ADDR_BITS'(AW'(BASE_ADDR) + AW'(cur_k_q) * AW'(KERNEL_TAPS) + AW'(tap_q))
        : ADDR_BITS'(BASE_ADDR);

    weight_fetch_ctrl_kernel_pack_reg #(
        .TAPS     (KERNEL_TAPS),
        .WIDTH    (RAM_WIDTH),
        .TAP_BITS (TAP_BITS)
    ) u_pack (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (fetching),
        .wr_tap_i (tap_q),
        .wr_dat_i (bus.rom_data),
        .data_o   (bus.kernel_data)
    );

    assign bus.kernel_idx   = cur_k_q;
    assign bus.kernel_valid = (state_q == ST_HOLD);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.done         = done_q;
    assign bus.sel_err      = sel_err_q;
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Randomized bench for weight_fetch_ctrl against a cycle-count/arithmetic reference model.
// Latency: n/a. Backpressure: bench drives kernel_ready randomly and in fixed patterns.
module tb_weight_fetch_ctrl;
    localparam int RW    = 4;
    localparam int AB    = 6;
    localparam int TAPS  = 9;
    localparam int NK    = 7;
    localparam int KS    = 3;
    localparam int BASE  = weight_fetch_ctrl_pkg::WFC_BASE_ADDR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [RW-1:0] rom [0:(1<<AB)-1];

    weight_fetch_ctrl_if #(.RAM_WIDTH(RW), .ADDR_BITS(AB), .KERNEL_TAPS(TAPS), .KSEL_BITS(KS)) bus ();

    weight_fetch_ctrl #(
        .RAM_WIDTH(RW), .ADDR_BITS(AB), .KERNEL_TAPS(TAPS),
        .NUM_KERNELS(NK), .BASE_ADDR(BASE), .KSEL_BITS(KS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected packed kernel: tap t of kernel k sits at ROM word BASE + k*TAPS + t.
    function automatic logic [TAPS*RW-1:0] exp_kernel(input int k);
        logic [TAPS*RW-1:0] r;
        r = '0;
        for (int t = 0; t < TAPS; t++) r[t*RW +: RW] = RW'((BASE + k*TAPS + t) % 16);
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'(bus.busy), 64'(0));
        chk({tag, "_valid"}, 64'(bus.kernel_valid), 64'(0));
        chk({tag, "_done"},  64'(bus.done), 64'(0));
        chk({tag, "_err"},   64'(bus.sel_err), 64'(0));
        chk({tag, "_addr"},  64'(bus.rom_addr), 64'(BASE));
        chk({tag, "_data"},  64'(bus.kernel_data), 64'(0));
        chk({tag, "_idx"},   64'(bus.kernel_idx), 64'(0));
    endtask

    // Single-kernel request; ready raised dly cycles after valid; optional collision in FETCH.
    task automatic run_single(input int k, input int dly, input bit collide);
        bus.kernel_ready = 1'b0;
        bus.kernel_sel   = KS'(k);
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int t = 0; t < TAPS; t++) begin
            chk("fetch_addr", 64'(bus.rom_addr), 64'(BASE + k*TAPS + t));
            chk("fetch_busy_valid", 64'({bus.busy, bus.kernel_valid}), 64'(2'b10));
            if (collide && t == 3) begin
                bus.start      = 1'b1;
                bus.start_all  = 1'b1;
                bus.kernel_sel = KS'($urandom_range(0, 7));
            end else begin
                bus.start     = 1'b0;
                bus.start_all = 1'b0;
            end
            tick();
            if (collide && t == 3) chk("collide_no_err", 64'(bus.sel_err), 64'(0));
        end
        bus.start     = 1'b0;
        bus.start_all = 1'b0;
        for (int d = 0; d <= dly; d++) begin
            chk("hold_valid", 64'(bus.kernel_valid), 64'(1));
            chk("hold_data",  64'(bus.kernel_data), 64'(exp_kernel(k)));
            chk("hold_idx",   64'(bus.kernel_idx), 64'(k));
            chk("hold_done",  64'(bus.done), 64'(0));
            if (d == dly) bus.kernel_ready = 1'b1;
            tick();
        end
        bus.kernel_ready = 1'b0;
        chk("single_done", 64'(bus.done), 64'(1));
        chk("single_idle", 64'({bus.busy, bus.kernel_valid}), 64'(0));
        chk("single_addr", 64'(bus.rom_addr), 64'(BASE));
        tick();
        chk("single_done_pulse", 64'(bus.done), 64'(0));
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.start_all    = 1'b0;
        bus.kernel_sel   = '0;
        bus.kernel_ready = 1'b0;
        for (int i = 0; i < (1 << AB); i++) rom[i] = RW'(i % 16);

        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        // Directed single fetch: kernel 2, ready on cycle 12, done on cycle 13.
        run_single(2, 2, 1'b0);
        // Backpressure: ready held low for 20 HOLD cycles.
        run_single(5, 20, 1'b0);
        // Collision during FETCH.
        run_single(4, 1, 1'b1);

        // Invalid kernel select.
        bus.kernel_sel = 3'd7;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("selerr_pulse", 64'(bus.sel_err), 64'(1));
        chk("selerr_busy",  64'(bus.busy), 64'(0));
        chk("selerr_addr",  64'(bus.rom_addr), 64'(BASE));
        tick();
        chk("selerr_clear", 64'(bus.sel_err), 64'(0));
        chk("selerr_idle",  64'(bus.busy), 64'(0));

        // Randomized single fetches.
        for (int n = 0; n < 12; n++) begin
            run_single(int'($urandom_range(0, NK-1)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        // Sweep with ready tied high: kernel j valid on cycle 10*(j+1), done on cycle 71.
        bus.kernel_ready = 1'b1;
        bus.start_all    = 1'b1;
        tick();
        bus.start_all = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            bit fetch_e;
            bit valid_e;
            fetch_e = (c <= 70) && ((c - 1) % 10 < 9);
            valid_e = (c % 10 == 0) && (c >= 10) && (c <= 70);
            chk("sweep_addr",  64'(bus.rom_addr),
                64'(fetch_e ? BASE + ((c - 1) / 10) * TAPS + (c - 1) % 10 : BASE));
            chk("sweep_valid", 64'(bus.kernel_valid), 64'(valid_e));
            chk("sweep_busy",  64'(bus.busy), 64'(c <= 70));
            chk("sweep_done",  64'(bus.done), 64'(c == 71));
            if (valid_e) begin
                chk("sweep_idx",  64'(bus.kernel_idx), 64'(c / 10 - 1));
                chk("sweep_data", 64'(bus.kernel_data), 64'(exp_kernel(c / 10 - 1)));
            end
            tick();
        end
        bus.kernel_ready = 1'b0;

        // Sweep with random ready; start_all and start together (start_all wins).
        begin
            int h;
            int nexp;
            int c;
            h    = 0;
            nexp = 0;
            bus.start_all  = 1'b1;
            bus.start      = 1'b1;
            bus.kernel_sel = 3'd3;
            tick();
            bus.start_all = 1'b0;
            bus.start     = 1'b0;
            c = 1;
            while (!(nexp == NK && c >= h + 2) && c < 3000) begin
                bit valid_e;
                valid_e = (nexp < NK) && (c >= h + 10);
                chk("rsweep_valid", 64'(bus.kernel_valid), 64'(valid_e));
                chk("rsweep_done",  64'(bus.done), 64'(nexp == NK && c == h + 1));
                if (valid_e) begin
                    chk("rsweep_idx",  64'(bus.kernel_idx), 64'(nexp));
                    chk("rsweep_data", 64'(bus.kernel_data), 64'(exp_kernel(nexp)));
                end
                bus.kernel_ready = ($urandom_range(0, 2) == 0);
                if (valid_e && bus.kernel_ready) begin
                    h = c;
                    nexp++;
                end
                tick();
                c++;
            end
            bus.kernel_ready = 1'b0;
            chk("rsweep_count", 64'(nexp), 64'(NK));
            chk("rsweep_idle",  64'(bus.busy), 64'(0));
        end

        // Async reset at tap 4 of kernel 3 in a sweep.
        bus.kernel_ready = 1'b1;
        bus.start_all    = 1'b1;
        tick();
        bus.start_all = 1'b0;
        for (int c = 1; c < 35; c++) tick();
        chk("prerst_addr", 64'(bus.rom_addr), 64'(BASE + 3*TAPS + 4));
        chk("prerst_idx",  64'(bus.kernel_idx), 64'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        bus.kernel_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("after_rst_done", 64'(bus.done), 64'(0));
        chk("after_rst_busy", 64'(bus.busy), 64'(0));
        run_single(0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Sequencer that drives the address port of the kernel-weight ROM (asynchronous-read, RAM_WIDTH-bit words). It fetches one convolution kernel of KERNEL_TAPS weights tap by tap and packs them into a parallel word. The packed kernel goes to the convolution engine over a valid/ready handshake. It supports a single-kernel fetch and a sweep of all kernels in order, and sits between the layer control FSM and the ROM/conv datapath.

## Interface
Parameters:
- RAM_WIDTH, 4, weight word width; must match the ROM.
- ADDR_BITS, 6, ROM address width.
- KERNEL_TAPS, 9, weights per kernel (3x3).
- NUM_KERNELS, 7, kernels stored; BASE_ADDR + NUM_KERNELS*KERNEL_TAPS <= 2**ADDR_BITS.
- BASE_ADDR, 0, ROM address of tap 0 of kernel 0.
- KSEL_BITS, 3, width of kernel index.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request: fetch kernel kernel_sel.
- start_all  in  1  one-cycle request: sweep kernels 0..NUM_KERNELS-1.
- kernel_sel  in  KSEL_BITS  kernel index, sampled with start.
- rom_addr  out  ADDR_BITS  address to ROM addr_vector.
- rom_data  in  RAM_WIDTH  ROM dataOut (combinational from rom_addr).
- kernel_data  out  KERNEL_TAPS*RAM_WIDTH  packed kernel; tap 0 in bits [RAM_WIDTH-1:0].
- kernel_idx  out  KSEL_BITS  index of kernel on kernel_data.
- kernel_valid  out  1  kernel_data valid.
- kernel_ready  in  1  consumer accepts.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after last handshake of a request.
- sel_err  out  1  one-cycle pulse: kernel_sel >= NUM_KERNELS.

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE:
  - start with valid kernel_sel -> FETCH, with cur_k=kernel_sel, tap=0, sweep=0.
  - start_all -> FETCH, with cur_k=0, tap=0, sweep=1. start_all has priority if both are asserted.
  - start with kernel_sel >= NUM_KERNELS -> sel_err pulse next cycle; stay IDLE.
- FETCH:
  - rom_addr = BASE_ADDR + cur_k*KERNEL_TAPS + tap, computed from registered cur_k and tap.
  - Each cycle, rom_data is captured into slot tap of the pack register and tap increments.
  - On tap == KERNEL_TAPS-1: capture, clear tap, go to HOLD.
- HOLD:
  - kernel_valid=1; kernel_data and kernel_idx are stable.
  - On kernel_valid & kernel_ready:
    - if sweep and cur_k < NUM_KERNELS-1: cur_k++, go to FETCH;
    - else: done pulse, go to IDLE.
- start and start_all are ignored while busy.
- The pack register is not cleared between kernels; each slot is overwritten during FETCH. kernel_data is only meaningful while kernel_valid=1.
- rom_addr = BASE_ADDR when not in FETCH.
- Address arithmetic is done at ADDR_BITS+KSEL_BITS width, then truncated; the parameter constraint guarantees no wrap.

## Timing
- Reset values:
  - state=IDLE; busy, kernel_valid, done, sel_err all 0.
  - rom_addr=BASE_ADDR; kernel_data=0; kernel_idx=0.
  - Internal tap, cur_k and sweep are all 0.
- Single-kernel latency: start at cycle 0 -> FETCH cycles 1..KERNEL_TAPS -> kernel_valid high from cycle KERNEL_TAPS+1.
- done is asserted the cycle after the accepting handshake, coincident with IDLE.
- In a sweep, the next kernel's FETCH starts the cycle after the handshake, so there are KERNEL_TAPS dead cycles between kernels.
- kernel_valid, once high, stays high until the handshake; kernel_data does not change while valid.
- ready may be held high permanently. If so, each kernel is held for exactly one cycle.
- busy asserts the cycle after an accepted start and deasserts with done.
- rst_n low at any time, including mid-FETCH or HOLD, clears everything immediately: no done pulse, and the in-flight request is lost.

## Structure
- Shared CNN package holds:
  - state encoding: IDLE=2'd0, FETCH=2'd1, HOLD=2'd2;
  - default KERNEL_TAPS and NUM_KERNELS;
  - the BASE_ADDR constant shared with the ROM init range.
- One sub-module is natural: kernel_pack_reg. It is a KERNEL_TAPS x RAM_WIDTH register with tap-indexed write enable. The FSM, counters and address generation stay in the top.
- The ROM is instantiated by the parent, not inside this block.

## Test plan
- Bench ROM: ROM model filled with word[i] = i mod 16.
- Single fetch: start, kernel_sel=2.
  - rom_addr steps 18..26 on cycles 1..9.
  - kernel_valid rises on cycle 10.
  - kernel_data = {10,9,8,7,6,5,4,3,2} (tap 8..0), kernel_idx=2.
  - kernel_ready on cycle 12 -> done on cycle 13, busy=0.
- Backpressure: hold kernel_ready=0 for 20 cycles in HOLD.
  - kernel_valid stays 1 and kernel_data stays stable; no done.
  - Assert ready -> one handshake, then done.
- Sweep: start_all with ready tied high.
  - 7 valid pulses with kernel_idx 0..6, spaced 10 cycles apart.
  - Kernel 6 = addrs 54..62.
  - Exactly one done, after the 7th handshake.
- Errors and collisions:
  - start, kernel_sel=7 -> sel_err pulse, busy stays 0, rom_addr=BASE_ADDR.
  - start during FETCH -> ignored; current kernel index is unchanged.
- Async reset: drop rst_n at tap 4 of kernel 3 in a sweep.
  - All outputs go to reset values immediately.
  - After release, a new start with kernel_sel=0 fetches addrs 0..8 correctly.
